// File: rtl/rv32i_wb_io_port.sv
// rv32i_wb_io_port: buffered writeback output port.
// FIFO-queued words driven onto IO pins, passthrough or serialised.
module rv32i_wb_io_port #(
  parameter int DATA_W = 32,
  parameter int IO_W   = 16,
  parameter int DEPTH  = 4,
  parameter int HOLD   = 1
) (
  input  logic              clk,
  input  logic              RN,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mode,
  input  logic              oe_en,
  input  logic              clr_ovf,
  output logic [IO_W-1:0]   WB_OUT,
  output logic [IO_W-1:0]   io_oeb,
  output logic              beat_strb,
  output logic              frame,
  output logic              overflow,
  output logic              busy
);

  localparam int BEATS = DATA_W / IO_W;
  localparam int AW = $clog2(DEPTH);
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS-1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD-1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

  state_t            state, state_n;
  logic [BW-1:0]     beat_idx, beat_n;
  logic [HW-1:0]     hold_cnt, hold_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic              mode_q, mode_n;
  logic [IO_W-1:0]   out_n;
  logic              strb_n;
  logic              frame_n;
  logic              load;
  logic [BW-1:0]     last_beat;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign push     = wb_valid & ~full;
  assign head     = mem[rd_ptr];
  assign wb_ready = ~full;
  assign busy     = (state != IDLE) | ~empty;
  assign last_beat = mode_q ? BEAT_LAST : '0;

  // FIFO storage; contents need no reset, count guards validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wb_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge RN) begin
    if (RN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Serialiser next-state: beat advance, word load, idle return
  always_comb begin
    state_n = state;
    beat_n  = beat_idx;
    hold_n  = hold_cnt;
    sh_n    = sh;
    mode_n  = mode_q;
    out_n   = WB_OUT;
    strb_n  = 1'b0;
    frame_n = 1'b0;
    load    = 1'b0;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) load = 1'b1;
      end
      SHIFT: begin
        if (hold_cnt == HOLD_LAST) begin
          if (beat_idx < last_beat) begin
            beat_n = beat_idx + 1'b1;
            hold_n = '0;
            out_n  = sh[IO_W-1:0];
            sh_n   = sh >> IO_W;
            strb_n = 1'b1;
          end else if (!empty) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
    endcase
    if (load) begin
      pop     = 1'b1;
      state_n = SHIFT;
      mode_n  = mode;
      beat_n  = '0;
      hold_n  = '0;
      out_n   = head[IO_W-1:0];
      sh_n    = head >> IO_W;
      strb_n  = 1'b1;
      frame_n = 1'b1;
    end
  end

  // State register and registered pin outputs
  always_ff @(posedge clk or posedge RN) begin
    if (RN) begin
      state     <= IDLE;
      beat_idx  <= '0;
      hold_cnt  <= '0;
      sh        <= '0;
      mode_q    <= 1'b0;
      WB_OUT    <= '0;
      beat_strb <= 1'b0;
      frame     <= 1'b0;
    end else begin
      state     <= state_n;
      beat_idx  <= beat_n;
      hold_cnt  <= hold_n;
      sh        <= sh_n;
      mode_q    <= mode_n;
      WB_OUT    <= out_n;
      beat_strb <= strb_n;
      frame     <= frame_n;
    end
  end

  // Sticky overflow; a new drop beats a simultaneous clear
  always_ff @(posedge clk or posedge RN) begin
    if (RN)                   overflow <= 1'b0;
    else if (wb_valid & full) overflow <= 1'b1;
    else if (clr_ovf)         overflow <= 1'b0;
  end

  // Pin drive enable, independent of the serialiser
  always_ff @(posedge clk or posedge RN) begin
    if (RN) io_oeb <= '1;
    else    io_oeb <= {IO_W{~oe_en}};
  end

endmodule

// File: tb/tb_rv32i_wb_io_port.sv
// tb_rv32i_wb_io_port: directed checks of the writeback IO port.
// Instance a uses HOLD=1, instance b uses HOLD=4.
module tb_rv32i_wb_io_port;

  logic        clk;
  logic        RN;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        mode;
  logic        oe_en;
  logic        clr_ovf;

  logic        a_ready, a_strb, a_frame, a_ovf, a_busy;
  logic [15:0] a_out, a_oeb;
  logic        b_ready, b_strb, b_frame, b_ovf, b_busy;
  logic [15:0] b_out, b_oeb;

  int n_assert = 0;
  int n_fail = 0;
  int nb, last, nf;
  logic [15:0] ev, lastv;
  logic [31:0] w [5] = '{32'h1111_0000, 32'h3333_2222,
                         32'h5555_4444, 32'h7777_6666,
                         32'h9999_8888};

  rv32i_wb_io_port #(.HOLD(1)) u_a (
    .clk(clk), .RN(RN), .wb_valid(wb_valid),
    .wb_ready(a_ready), .wb_data(wb_data), .mode(mode),
    .oe_en(oe_en), .clr_ovf(clr_ovf), .WB_OUT(a_out),
    .io_oeb(a_oeb), .beat_strb(a_strb), .frame(a_frame),
    .overflow(a_ovf), .busy(a_busy)
  );

  rv32i_wb_io_port #(.HOLD(4)) u_b (
    .clk(clk), .RN(RN), .wb_valid(wb_valid),
    .wb_ready(b_ready), .wb_data(wb_data), .mode(mode),
    .oe_en(oe_en), .clr_ovf(clr_ovf), .WB_OUT(b_out),
    .io_oeb(b_oeb), .beat_strb(b_strb), .frame(b_frame),
    .overflow(b_ovf), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic got,
                      input logic want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, want);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] got,
                       input logic [15:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic chki(input string tag, input int got,
                      input int want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic do_reset();
    RN = 1'b1;
    tick();
    RN = 1'b0;
    tick();
  endtask

  initial begin
    RN = 1'b1; wb_valid = 1'b0; wb_data = '0;
    mode = 1'b0; oe_en = 1'b1; clr_ovf = 1'b0;
    tick(); tick();
    chk16("oeb_in_reset", a_oeb, 16'hFFFF);
    RN = 1'b0;
    tick();
    chk16("oeb_after_release", a_oeb, 16'h0000);

    // reset mid-run with pins enabled
    wb_valid = 1'b1; wb_data = 32'hCAFE_F00D; mode = 1'b1;
    tick();
    wb_valid = 1'b0;
    tick();
    chk16("pre_reset_out", a_out, 16'hF00D);
    #3 RN = 1'b1;
    #1;
    chk16("rst_out", a_out, 16'h0000);
    chk16("rst_oeb", a_oeb, 16'hFFFF);
    chk1("rst_strb", a_strb, 1'b0);
    chk1("rst_frame", a_frame, 1'b0);
    chk1("rst_busy", a_busy, 1'b0);
    chk1("rst_ready", a_ready, 1'b1);
    tick();
    RN = 1'b0;
    chk16("oeb_release_lat", a_oeb, 16'hFFFF);
    tick();
    chk16("oeb_release_1cyc", a_oeb, 16'h0000);
    chk1("rst_no_beat", a_strb, 1'b0);

    // passthrough
    mode = 1'b0; wb_valid = 1'b1; wb_data = 32'hDEAD_BEEF;
    tick();
    wb_valid = 1'b0;
    chk1("pt_busy_queued", a_busy, 1'b1);
    chk1("pt_no_strb_yet", a_strb, 1'b0);
    tick();
    chk16("pt_out", a_out, 16'hBEEF);
    chk1("pt_strb", a_strb, 1'b1);
    chk1("pt_frame", a_frame, 1'b1);
    chk1("pt_busy", a_busy, 1'b1);
    tick();
    chk1("pt_strb_low", a_strb, 1'b0);
    chk1("pt_frame_low", a_frame, 1'b0);
    chk16("pt_out_hold", a_out, 16'hBEEF);
    chk1("pt_busy_drop", a_busy, 1'b0);

    // serialised, mode toggled mid-word
    mode = 1'b1; wb_valid = 1'b1; wb_data = 32'h1234_5678;
    tick();
    wb_valid = 1'b0;
    tick();
    chk16("ser_b0", a_out, 16'h5678);
    chk1("ser_b0_frame", a_frame, 1'b1);
    chk1("ser_b0_strb", a_strb, 1'b1);
    mode = 1'b0;
    tick();
    chk16("ser_b1", a_out, 16'h1234);
    chk1("ser_b1_strb", a_strb, 1'b1);
    chk1("ser_b1_frame", a_frame, 1'b0);
    chk1("ser_b1_busy", a_busy, 1'b1);
    tick();
    chk1("ser_end_strb", a_strb, 1'b0);
    chk1("ser_end_busy", a_busy, 1'b0);
    chk16("ser_end_out", a_out, 16'h1234);

    // burst on HOLD=4
    do_reset();
    mode = 1'b1; wb_valid = 1'b1; wb_data = w[0];
    nb = 0; last = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (i == 3) chk1("burst_ready_3q", b_ready, 1'b1);
      if (i == 4) chk1("burst_ready_full", b_ready, 1'b0);
      if (b_strb) begin
        if (nb < 10) begin
          ev = nb[0] ? w[nb/2][31:16] : w[nb/2][15:0];
          chk16("burst_beat", b_out, ev);
          chk1("burst_frame", b_frame, ~nb[0]);
          if (nb > 0) chki("burst_gap", i - last, 4);
        end
        last = i;
        nb++;
      end
      if (i + 1 < 5) begin
        wb_valid = 1'b1; wb_data = w[i+1];
      end else begin
        wb_valid = 1'b0;
      end
    end
    chki("burst_beats", nb, 10);
    chk1("burst_busy_end", b_busy, 1'b0);
    chk1("burst_no_ovf", b_ovf, 1'b0);

    // overflow
    do_reset();
    mode = 1'b1; wb_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      wb_data = w[j];
      tick();
    end
    chk1("ovf_not_yet", b_ovf, 1'b0);
    chk1("ovf_full", b_ready, 1'b0);
    wb_data = 32'hBAD0_BAD1;
    tick();
    chk1("ovf_set", b_ovf, 1'b1);
    wb_valid = 1'b0; clr_ovf = 1'b1;
    tick();
    chk1("ovf_cleared", b_ovf, 1'b0);
    wb_valid = 1'b1; wb_data = 32'hBAD2_BAD3;
    tick();
    chk1("ovf_set_wins", b_ovf, 1'b1);
    wb_valid = 1'b0; clr_ovf = 1'b0;
    tick();
    chk1("ovf_sticky", b_ovf, 1'b1);
    nf = 0; lastv = '0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (b_frame) nf++;
      if (b_strb) lastv = b_out;
    end
    chki("ovf_frames_left", nf, 4);
    chk16("ovf_last_beat", lastv, 16'h9999);

    // reset mid-beat with queued words
    do_reset();
    mode = 1'b1; wb_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      wb_data = w[j];
      tick();
    end
    wb_valid = 1'b0;
    tick(); tick(); tick();
    chk1("mb_beat1_strb", b_strb, 1'b1);
    chk16("mb_beat1_out", b_out, 16'h1111);
    tick();
    #3 RN = 1'b1;
    #1;
    chk16("mb_rst_out", b_out, 16'h0000);
    chk1("mb_rst_busy", b_busy, 1'b0);
    chk1("mb_rst_ready", b_ready, 1'b1);
    tick();
    RN = 1'b0;
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (b_strb) nb++;
    end
    chki("mb_no_beats", nb, 0);
    chk1("mb_idle", b_busy, 1'b0);
    wb_valid = 1'b1; wb_data = 32'hABCD_1234;
    tick();
    wb_valid = 1'b0;
    tick();
    chk1("mb_new_strb", b_strb, 1'b1);
    chk1("mb_new_frame", b_frame, 1'b1);
    chk16("mb_new_out", b_out, 16'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
